// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-side arbiter.
// Collects scalar FU completions (ALU, scalar LD/ST, branch) into one holding
// slot per source. It commits at most one scalar register write per cycle,
// picking among the slots in round-robin order. A result produced under an
// unresolved branch is held until the branch is resolved, and it is dropped
// on a mispredict. Matrix completions (matrix LD/ST, GEMM) use a separate
// path: one write per cycle, with a single pending entry for a GEMM result
// that collides with an LD/ST completion.
module wb_arbiter #(
  parameter int WORD_W = 32,
  parameter int SREG_W = 5,
  parameter int MREG_W = 4,
  parameter int NSRC   = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NSRC-1:0]        s_valid,
  output logic [NSRC-1:0]        s_ready,
  input  logic [NSRC-1:0]        s_wen,
  input  logic [NSRC*SREG_W-1:0] s_rd,
  input  logic [NSRC*WORD_W-1:0] s_data,
  input  logic [NSRC-1:0]        s_spec,
  input  logic                   branch_resolved,
  input  logic                   branch_miss,
  input  logic                   mls_done,
  input  logic [MREG_W-1:0]      mls_md,
  input  logic                   gemm_done,
  input  logic [MREG_W-1:0]      gemm_md,
  output logic                   gemm_ready,
  output logic                   s_rw_en,
  output logic [SREG_W-1:0]      s_rw,
  output logic [WORD_W-1:0]      s_wdata,
  output logic                   m_rw_en,
  output logic [MREG_W-1:0]      m_rw,
  output logic [1:0]             fu_ex
);

  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  // Holding slots, one per scalar source
  logic [NSRC-1:0]             r_valid;
  logic [NSRC-1:0]             r_wen;
  logic [NSRC-1:0]             r_spec;
  logic [NSRC-1:0][SREG_W-1:0] r_rd;
  logic [NSRC-1:0][WORD_W-1:0] r_data;
  logic [PTR_W-1:0]            r_ptr;

  // Registered writeback bundle
  logic              r_s_rw_en;
  logic [SREG_W-1:0] r_s_rw;
  logic [WORD_W-1:0] r_s_wdata;
  logic [1:0]        r_fu_ex;
  logic              r_m_rw_en;
  logic [MREG_W-1:0] r_m_rw;
  logic              r_m_pending;
  logic [MREG_W-1:0] r_m_pend_md;

  // Arbitration signals
  logic [NSRC-1:0]  w_elig;
  logic [NSRC-1:0]  w_grant;
  logic [NSRC-1:0]  w_accept;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [PTR_W-1:0] w_cand;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_gnt_any;

  assign w_elig     = r_valid & ~r_spec;
  assign s_ready    = ~r_valid | w_grant;
  assign w_accept   = s_valid & s_ready;
  assign gemm_ready = ~r_m_pending;

  assign s_rw_en = r_s_rw_en;
  assign s_rw    = r_s_rw;
  assign s_wdata = r_s_wdata;
  assign fu_ex   = r_fu_ex;
  assign m_rw_en = r_m_rw_en;
  assign m_rw    = r_m_rw;

  // Round-robin search: pick the first eligible slot, starting at the pointer
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % NSRC);
      if (!w_gnt_any && w_elig[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_gnt_any) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  // After a grant, the pointer moves to the next index after the winner
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_gnt_any) begin
      w_ptr_next = (int'(w_gnt_idx) == NSRC - 1) ? '0 : w_gnt_idx + PTR_W'(1);
    end
  end

  // Slot update. A new accept takes priority over the other cases, because a
  // slot being drained by a grant can reload in the same edge. If a mispredict
  // and a resolve arrive together, the mispredict wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= '0;
      r_wen   <= '0;
      r_spec  <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (w_accept[i]) begin
          r_valid[i] <= ~(branch_miss & s_spec[i]);
          r_wen[i]   <= s_wen[i];
          r_rd[i]    <= s_rd[i*SREG_W +: SREG_W];
          r_data[i]  <= s_data[i*WORD_W +: WORD_W];
          r_spec[i]  <= s_spec[i] & ~branch_resolved & ~branch_miss;
        end else if (w_grant[i]) begin
          r_valid[i] <= 1'b0;
        end else if (branch_miss && r_spec[i]) begin
          r_valid[i] <= 1'b0;
          r_spec[i]  <= 1'b0;
        end else if (branch_resolved) begin
          r_spec[i]  <= 1'b0;
        end
      end
      r_ptr <= w_ptr_next;
    end
  end

  // Scalar writeback register: holds the granted slot for exactly one cycle.
  // Writes to x0 are reported as completions, but they do not write a register.
  always_ff @(posedge CLK) begin
    if (RST || !w_gnt_any) begin
      r_s_rw_en <= 1'b0;
      r_s_rw    <= '0;
      r_s_wdata <= '0;
      r_fu_ex   <= 2'd0;
    end else begin
      r_s_rw_en <= r_wen[w_gnt_idx] & (|r_rd[w_gnt_idx]);
      r_s_rw    <= r_rd[w_gnt_idx];
      r_s_wdata <= r_data[w_gnt_idx];
      r_fu_ex   <= 2'(w_gnt_idx) + 2'd1;
    end
  end

  // Matrix writeback. An LD/ST completion always goes out first. A GEMM
  // completion that collides with it is parked in the single pending entry.
  // GEMM is held off through gemm_ready until that entry drains.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_m_rw_en   <= 1'b0;
      r_m_rw      <= '0;
      r_m_pending <= 1'b0;
      r_m_pend_md <= '0;
    end else if (mls_done) begin
      r_m_rw_en <= 1'b1;
      r_m_rw    <= mls_md;
      if (gemm_done && !r_m_pending) begin
        r_m_pending <= 1'b1;
        r_m_pend_md <= gemm_md;
      end
    end else if (r_m_pending) begin
      r_m_rw_en   <= 1'b1;
      r_m_rw      <= r_m_pend_md;
      r_m_pending <= 1'b0;
    end else if (gemm_done) begin
      r_m_rw_en <= 1'b1;
      r_m_rw    <= gemm_md;
    end else begin
      r_m_rw_en <= 1'b0;
      r_m_rw    <= '0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus a randomized run, checked against
// a behavioural model of the writeback arbiter.
module tb_wb_arbiter;

  logic        CLK;
  logic        RST;
  logic [2:0]  s_valid;
  logic [2:0]  s_ready;
  logic [2:0]  s_wen;
  logic [14:0] s_rd;
  logic [95:0] s_data;
  logic [2:0]  s_spec;
  logic        branch_resolved;
  logic        branch_miss;
  logic        mls_done;
  logic [3:0]  mls_md;
  logic        gemm_done;
  logic [3:0]  gemm_md;
  logic        gemm_ready;
  logic        s_rw_en;
  logic [4:0]  s_rw;
  logic [31:0] s_wdata;
  logic        m_rw_en;
  logic [3:0]  m_rw;
  logic [1:0]  fu_ex;

  int nCompared;
  int nMismatched;

  // {s_rw_en, s_rw, s_wdata, fu_ex} and {gemm_ready, m_rw_en, m_rw}
  logic [39:0] scalarOut;
  logic [5:0]  matrixOut;
  assign scalarOut = {s_rw_en, s_rw, s_wdata, fu_ex};
  assign matrixOut = {gemm_ready, m_rw_en, m_rw};

  wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_wen(s_wen), .s_rd(s_rd),
    .s_data(s_data), .s_spec(s_spec),
    .branch_resolved(branch_resolved), .branch_miss(branch_miss),
    .mls_done(mls_done), .mls_md(mls_md), .gemm_done(gemm_done), .gemm_md(gemm_md),
    .gemm_ready(gemm_ready), .s_rw_en(s_rw_en), .s_rw(s_rw), .s_wdata(s_wdata),
    .m_rw_en(m_rw_en), .m_rw(m_rw), .fu_ex(fu_ex)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance past the next rising edge; outputs are stable when this returns
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    s_valid = '0; s_wen = '0; s_rd = '0; s_data = '0; s_spec = '0;
    branch_resolved = 1'b0; branch_miss = 1'b0;
    mls_done = 1'b0; mls_md = '0; gemm_done = 1'b0; gemm_md = '0;
  endtask

  task automatic setSrc(input int i, input bit wen, input logic [4:0] rd,
                        input logic [31:0] data, input bit spec);
    s_valid[i] = 1'b1;
    s_wen[i] = wen;
    s_rd[i*5 +: 5] = rd;
    s_data[i*32 +: 32] = data;
    s_spec[i] = spec;
  endtask

  task automatic doReset();
    clearInputs();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // Idle state after reset
  task automatic test_reset();
    doReset();
    nCompared++; if (scalarOut !== 40'd0) begin nMismatched++; $display("[TB] FAIL reset_scalar got %h want %h", scalarOut, 40'd0); end
    nCompared++; if (matrixOut !== 6'b100000) begin nMismatched++; $display("[TB] FAIL reset_matrix got %b want %b", matrixOut, 6'b100000); end
    nCompared++; if (s_ready !== 3'b111) begin nMismatched++; $display("[TB] FAIL reset_ready got %b want %b", s_ready, 3'b111); end
  endtask

  // A single ALU result commits one edge after it is accepted
  task automatic test_single_alu();
    doReset();
    setSrc(0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    step();
    clearInputs();
    nCompared++; if (scalarOut !== 40'd0) begin nMismatched++; $display("[TB] FAIL alu_early got %h want %h", scalarOut, 40'd0); end
    nCompared++; if (s_ready !== 3'b111) begin nMismatched++; $display("[TB] FAIL alu_ready got %b want %b", s_ready, 3'b111); end
    step();
    nCompared++; if (scalarOut !== {1'b1, 5'd5, 32'hDEADBEEF, 2'd1}) begin nMismatched++; $display("[TB] FAIL alu_commit got %h want %h", scalarOut, {1'b1, 5'd5, 32'hDEADBEEF, 2'd1}); end
    step();
    nCompared++; if (scalarOut !== 40'd0) begin nMismatched++; $display("[TB] FAIL alu_oneshot got %h want %h", scalarOut, 40'd0); end
  endtask

  // Three sources at once are drained 1,2,3, with backpressure while held
  task automatic test_all_three();
    logic [2:0] expReady [3];
    expReady[0] = 3'b001; expReady[1] = 3'b011; expReady[2] = 3'b111;
    doReset();
    setSrc(0, 1'b1, 5'd1, 32'h11111111, 1'b0);
    setSrc(1, 1'b1, 5'd2, 32'h22222222, 1'b0);
    setSrc(2, 1'b1, 5'd3, 32'h33333333, 1'b0);
    step();
    clearInputs();
    for (int c = 0; c < 3; c++) begin
      nCompared++; if (s_ready !== expReady[c]) begin nMismatched++; $display("[TB] FAIL three_ready%0d got %b want %b", c, s_ready, expReady[c]); end
      step();
      nCompared++; if (fu_ex !== 2'(c + 1) || s_rw !== 5'(c + 1)) begin nMismatched++; $display("[TB] FAIL three_seq%0d got fu_ex=%0d rd=%0d want %0d", c, fu_ex, s_rw, c + 1); end
    end
    // The pointer wraps to 0, so slot 0 beats slot 2 next
    setSrc(0, 1'b1, 5'd4, 32'h4, 1'b0);
    setSrc(2, 1'b1, 5'd6, 32'h6, 1'b0);
    step();
    clearInputs();
    step();
    nCompared++; if (fu_ex !== 2'd1) begin nMismatched++; $display("[TB] FAIL three_wrap got %0d want %0d", fu_ex, 1); end
    step();
    nCompared++; if (fu_ex !== 2'd3) begin nMismatched++; $display("[TB] FAIL three_wrap2 got %0d want %0d", fu_ex, 3); end
  endtask

  // A speculative result waits for branch_resolved
  task automatic test_spec_hold();
    doReset();
    setSrc(1, 1'b1, 5'd7, 32'hCAFEF00D, 1'b1);
    step();
    clearInputs();
    for (int c = 0; c < 3; c++) begin
      step();
      nCompared++; if (fu_ex !== 2'd0) begin nMismatched++; $display("[TB] FAIL spec_held%0d got %0d want %0d", c, fu_ex, 0); end
    end
    branch_resolved = 1'b1;
    step();
    branch_resolved = 1'b0;
    nCompared++; if (fu_ex !== 2'd0) begin nMismatched++; $display("[TB] FAIL spec_resolve_edge got %0d want %0d", fu_ex, 0); end
    step();
    nCompared++; if (scalarOut !== {1'b1, 5'd7, 32'hCAFEF00D, 2'd2}) begin nMismatched++; $display("[TB] FAIL spec_commit got %h want %h", scalarOut, {1'b1, 5'd7, 32'hCAFEF00D, 2'd2}); end
  endtask

  // A mispredict drops the held speculative ALU result; the branch still commits
  task automatic test_mispredict();
    doReset();
    setSrc(0, 1'b1, 5'd4, 32'hBAD0BAD0, 1'b1);
    setSrc(2, 1'b1, 5'd1, 32'h00001234, 1'b0);
    step();
    clearInputs();
    branch_miss = 1'b1;
    branch_resolved = 1'b1;
    step();
    clearInputs();
    nCompared++; if (scalarOut !== {1'b1, 5'd1, 32'h00001234, 2'd3}) begin nMismatched++; $display("[TB] FAIL miss_branch got %h want %h", scalarOut, {1'b1, 5'd1, 32'h00001234, 2'd3}); end
    nCompared++; if (s_ready !== 3'b111) begin nMismatched++; $display("[TB] FAIL miss_ready got %b want %b", s_ready, 3'b111); end
    for (int c = 0; c < 3; c++) begin
      step();
      nCompared++; if (fu_ex !== 2'd0) begin nMismatched++; $display("[TB] FAIL miss_dropped%0d got %0d want %0d", c, fu_ex, 0); end
    end
  endtask

  // Stores and x0 destinations complete without a register write
  task automatic test_store_x0();
    doReset();
    setSrc(1, 1'b0, 5'd9, 32'h99, 1'b0);
    step();
    clearInputs();
    step();
    nCompared++; if (scalarOut !== {1'b0, 5'd9, 32'h99, 2'd2}) begin nMismatched++; $display("[TB] FAIL store got %h want %h", scalarOut, {1'b0, 5'd9, 32'h99, 2'd2}); end
    setSrc(0, 1'b1, 5'd0, 32'h55, 1'b0);
    step();
    clearInputs();
    step();
    nCompared++; if (scalarOut !== {1'b0, 5'd0, 32'h55, 2'd1}) begin nMismatched++; $display("[TB] FAIL x0 got %h want %h", scalarOut, {1'b0, 5'd0, 32'h55, 2'd1}); end
  endtask

  // mls/gemm collision, then a reset while the pending entry is held
  task automatic test_matrix_collision();
    doReset();
    mls_done = 1'b1; mls_md = 4'd3; gemm_done = 1'b1; gemm_md = 4'd9;
    step();
    clearInputs();
    nCompared++; if (matrixOut !== {1'b0, 1'b1, 4'd3}) begin nMismatched++; $display("[TB] FAIL mat_first got %b want %b", matrixOut, {1'b0, 1'b1, 4'd3}); end
    step();
    nCompared++; if (matrixOut !== {1'b1, 1'b1, 4'd9}) begin nMismatched++; $display("[TB] FAIL mat_second got %b want %b", matrixOut, {1'b1, 1'b1, 4'd9}); end
    step();
    nCompared++; if (matrixOut !== {1'b1, 1'b0, 4'd0}) begin nMismatched++; $display("[TB] FAIL mat_idle got %b want %b", matrixOut, {1'b1, 1'b0, 4'd0}); end
    mls_done = 1'b1; mls_md = 4'd3; gemm_done = 1'b1; gemm_md = 4'd9;
    step();
    clearInputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    nCompared++; if (matrixOut !== {1'b1, 1'b0, 4'd0}) begin nMismatched++; $display("[TB] FAIL mat_reset got %b want %b", matrixOut, {1'b1, 1'b0, 4'd0}); end
    step();
    nCompared++; if (matrixOut !== {1'b1, 1'b0, 4'd0}) begin nMismatched++; $display("[TB] FAIL mat_after_reset got %b want %b", matrixOut, {1'b1, 1'b0, 4'd0}); end
  endtask

  // A reset while scalar results are held discards them silently
  task automatic test_reset_midop();
    doReset();
    setSrc(0, 1'b1, 5'd1, 32'h1, 1'b0);
    setSrc(1, 1'b1, 5'd2, 32'h2, 1'b0);
    setSrc(2, 1'b1, 5'd3, 32'h3, 1'b1);
    step();
    clearInputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    nCompared++; if (scalarOut !== 40'd0 || s_ready !== 3'b111) begin nMismatched++; $display("[TB] FAIL midop_reset got %h/%b want 0/111", scalarOut, s_ready); end
    step();
    nCompared++; if (scalarOut !== 40'd0) begin nMismatched++; $display("[TB] FAIL midop_after got %h want %h", scalarOut, 40'd0); end
  endtask

  // Random traffic against a behavioural model: per-source holding slots and
  // a round-robin turn for scalars; a FIFO backlog of GEMM results for matrix
  task automatic test_random();
    bit          mValid [3];
    bit          mWen [3];
    bit          mSpec [3];
    logic [4:0]  mRd [3];
    logic [31:0] mData [3];
    int          mTurn;
    logic [3:0]  backlog [$];
    logic [39:0] expScalar;
    logic [4:0]  expMatrix;
    logic [2:0]  expReady;
    int          winner;
    doReset();
    for (int i = 0; i < 3; i++) begin
      mValid[i] = 0; mWen[i] = 0; mSpec[i] = 0; mRd[i] = '0; mData[i] = '0;
    end
    mTurn = 0;
    backlog.delete();
    expScalar = '0;
    expMatrix = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nCompared++; if (scalarOut !== expScalar) begin nMismatched++; $display("[TB] FAIL rnd_scalar cyc=%0d got %h want %h", cyc, scalarOut, expScalar); end
      nCompared++; if ({m_rw_en, m_rw} !== expMatrix) begin nMismatched++; $display("[TB] FAIL rnd_matrix cyc=%0d got %b want %b", cyc, {m_rw_en, m_rw}, expMatrix); end
      nCompared++; if (gemm_ready !== (backlog.size() == 0)) begin nMismatched++; $display("[TB] FAIL rnd_gemm_ready cyc=%0d got %b want %b", cyc, gemm_ready, backlog.size() == 0); end

      winner = -1;
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (mTurn + k) % 3;
        if (winner < 0 && mValid[idx] && !mSpec[idx]) winner = idx;
      end
      for (int i = 0; i < 3; i++) expReady[i] = !mValid[i] || (winner == i);

      s_valid = 3'($urandom);
      s_wen = 3'($urandom);
      s_rd = 15'($urandom);
      s_data = {$urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) s_spec[i] = ($urandom % 4 == 0);
      branch_resolved = ($urandom % 6 == 0);
      branch_miss = ($urandom % 10 == 0);
      mls_done = ($urandom % 3 == 0);
      mls_md = 4'($urandom);
      gemm_done = (backlog.size() == 0) && ($urandom % 2 == 0);
      gemm_md = 4'($urandom);
      RST = ($urandom % 200 == 0);
      #1;
      nCompared++; if (s_ready !== expReady) begin nMismatched++; $display("[TB] FAIL rnd_ready cyc=%0d got %b want %b", cyc, s_ready, expReady); end

      if (RST) begin
        for (int i = 0; i < 3; i++) begin mValid[i] = 0; mSpec[i] = 0; end
        mTurn = 0;
        backlog.delete();
        expScalar = '0;
        expMatrix = '0;
      end else begin
        if (winner >= 0) begin
          expScalar = {mWen[winner] && (mRd[winner] != 0), mRd[winner], mData[winner], 2'(winner + 1)};
          mValid[winner] = 0;
          mTurn = (winner + 1) % 3;
        end else begin
          expScalar = '0;
        end
        for (int i = 0; i < 3; i++) begin
          if (mValid[i] && mSpec[i]) begin
            if (branch_miss) mValid[i] = 0;
            else if (branch_resolved) mSpec[i] = 0;
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (s_valid[i] && expReady[i] && !(branch_miss && s_spec[i])) begin
            mValid[i] = 1;
            mWen[i] = s_wen[i];
            mRd[i] = s_rd[i*5 +: 5];
            mData[i] = s_data[i*32 +: 32];
            mSpec[i] = s_spec[i] && !branch_resolved;
          end
        end
        if (gemm_done) backlog.push_back(gemm_md);
        if (mls_done) expMatrix = {1'b1, mls_md};
        else if (backlog.size() > 0) expMatrix = {1'b1, backlog.pop_front()};
        else expMatrix = '0;
      end
      @(posedge CLK);
      #1;
    end
    clearInputs();
    RST = 1'b0;
  endtask

  // Test sequence
  initial begin
    nCompared = 0;
    nMismatched = 0;
    RST = 1'b1;
    clearInputs();
    test_reset();
    test_single_alu();
    test_all_three();
    test_spec_hold();
    test_mispredict();
    test_store_x0();
    test_matrix_collision();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side counterpart to dispatch. Collects completions from the scalar FUs (ALU, scalar LD/ST, branch) and the matrix FUs (matrix LD/ST, GEMM).
- Arbitrates one scalar and one matrix register commit per cycle.
- Produces the registered writeback bundle (s_rw_en/s_rw/m_rw_en/m_rw) and the fu_ex completion code. Dispatch uses these to clear register-status-table entries and to wake FUST tags.
- Holds speculative scalar results until branch resolution and drops them on a mispredict.

Parameters:
WORD_W, 32, scalar data width
SREG_W, 5, scalar register index width
MREG_W, 4, matrix register index width
NSRC, 3, scalar sources (0=ALU, 1=scalar LD/ST, 2=branch); fixed at 3

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
s_valid  in  NSRC  per-source result valid
s_ready  out  NSRC  per-source accept
s_wen  in  NSRC  result writes a register (0 for stores and non-link branches)
s_rd  in  NSRC*SREG_W  destination register per source
s_data  in  NSRC*WORD_W  result data per source
s_spec  in  NSRC  result produced under an unresolved branch
branch_resolved  in  1  oldest branch predicted correctly
branch_miss  in  1  mispredict flush
mls_done  in  1  matrix LD/ST completion pulse
mls_md  in  MREG_W  matrix LD destination
gemm_done  in  1  GEMM completion pulse
gemm_md  in  MREG_W  GEMM destination
gemm_ready  out  1  GEMM may signal completion
s_rw_en  out  1  scalar register write
s_rw  out  SREG_W  scalar destination
s_wdata  out  WORD_W  scalar write data
m_rw_en  out  1  matrix register write
m_rw  out  MREG_W  matrix destination
fu_ex  out  2  completion code: 0=NONE, 1=ALU_DONE, 2=SCALAR_LS_DONE, 3=BRANCH_DONE

Behaviour:
- Reset (RST high at an edge):
  - All outputs 0.
  - All slots invalid.
  - RR pointer = 0.
  - m_pending = 0.
  - Reset mid-operation discards every held result with no output.
- Slots: one holding slot per scalar source, with fields {valid, wen, rd, data, spec}.
  - s_ready[i] = ~slot[i].valid | grant[i].
  - s_valid[i] & s_ready[i] at an edge loads the slot.
  - A slot freed by grant may reload in the same edge.
- Eligibility: slot valid & ~spec. Speculative slots are never granted.
- Arbitration: combinational round-robin over eligible slots.
  - Search starts at the RR pointer.
  - On grant, the pointer moves to the granted index +1, mod 3.
  - At most one grant per cycle.
- Output registers, loaded at the edge following the grant:
  - fu_ex = code of the granted source, else 0.
  - s_rw_en = wen & (rd != 0).
  - s_rw and s_wdata = slot contents, else 0.
  - Outputs are valid for exactly one cycle per grant.
- Latency: result accepted at edge k appears on the outputs after edge k+1 when uncontested. Worst case without spec is k+3.
- branch_resolved: clears the spec bit in all slots and in any accepting input at that edge. The cleared slot becomes eligible next cycle.
- branch_miss:
  - Invalidates every slot with spec=1.
  - Drops any incoming accept with s_spec=1; s_ready stays as computed and the transfer is consumed.
  - Non-spec slots and the current grant are unaffected.
  - If branch_miss and branch_resolved arrive together, branch_miss wins.
- Matrix path:
  - mls_done alone → next edge m_rw_en=1, m_rw=mls_md.
  - gemm_done alone with m_pending=0 → same, using gemm_md.
  - Both in the same cycle → mls is output first; gemm_md is latched into pending (m_pending=1) and output on the next edge.
  - A pending entry drains before any new gemm_done.
  - gemm_ready = ~m_pending.
  - A new mls_done arriving while pending drains is output ahead of pending; pending is never dropped.
  - Matrix results are never speculative and are unaffected by branch_miss.

Test Plan:
- Reset, then single ALU result: s_valid=001, rd=5, data=0xDEADBEEF, wen=1 at edge 1 → after edge 2: s_rw_en=1, s_rw=5, s_wdata=0xDEADBEEF, fu_ex=1 for one cycle; s_ready=111 throughout.
- All three sources valid in the same cycle (rd 1/2/3), pointer 0 → fu_ex sequence 1, 2, 3 over three cycles; pointer ends at 0; backpressure appears as s_ready[1]/s_ready[2]=0 until drained.
- Speculative hold: LD/ST result rd=7 with spec=1 → no output; branch_resolved asserted 3 cycles later → s_rw=7, fu_ex=2 two edges later.
- Mispredict: ALU spec=1 result held; branch slot (non-spec, rd=1) also valid; branch_miss and branch_resolved pulse together → ALU result never appears; branch result commits with fu_ex=3.
- Store/x0 filtering: LD/ST with wen=0, then ALU with rd=0 → fu_ex=2 then 1 reported, s_rw_en=0 both times.
- Matrix collision: mls_done (md=3) and gemm_done (md=9) in the same cycle → m_rw=3, then m_rw=9 on consecutive cycles; gemm_ready=0 for exactly one cycle. RST asserted while pending → no second write; gemm_ready=1 afterwards.
